// File: rtl/counter_sequencer.sv
// Sequencer for an external up-counter: clears it, runs it to a latched terminal
// value, supports pause/abort, and optionally reloads after each completed period.
module counter_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] terminal,
    input  logic [WIDTH-1:0] count_in,
    output logic             cnt_enable,
    output logic             cnt_reset,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] periods
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StPause,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] terminal_q, terminal_d;
    logic [WIDTH-1:0] periods_q, periods_d;
    logic             at_term;

    assign at_term = (count_in == terminal_q);
    assign periods = periods_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            terminal_q <= '0;
            periods_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            terminal_q <= terminal_d;
            periods_q  <= periods_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        terminal_d = terminal_q;
        periods_d  = periods_q;
        cnt_enable = 1'b0;
        cnt_reset  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    mode_d     = mode;
                    terminal_d = terminal;
                    periods_d  = '0;
                    state_d    = StClear;
                end
            end
            StClear: begin
                cnt_reset = 1'b1;
                state_d   = stop ? StIdle : StRun;
            end
            StRun: begin
                // Gate on stop/pause so the counter never moves in a transition cycle.
                cnt_enable = !at_term && !stop && !pause;
                if (stop) begin
                    state_d = StIdle;
                end else if (at_term) begin
                    state_d = StDone;
                end else if (pause) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (!pause) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                done = 1'b1;
                if (periods_q != {WIDTH{1'b1}}) begin
                    periods_d = periods_q + WIDTH'(1);
                end
                if (stop) begin
                    state_d = StIdle;
                end else begin
                    state_d = mode_q ? StClear : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench: the stimulus side predicts done/cnt_reset cycles arithmetically,
// a monitor pops and compares whenever the DUT pulses them.
module tb_counter_sequencer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, start, stop, pause, mode;
    logic [W-1:0] terminal;
    logic [W-1:0] count = '0;
    logic         cnt_enable, cnt_reset, busy, done;
    logic [W-1:0] periods;

    counter_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .mode       (mode),
        .terminal   (terminal),
        .count_in   (count),
        .cnt_enable (cnt_enable),
        .cnt_reset  (cnt_reset),
        .busy       (busy),
        .done       (done),
        .periods    (periods)
    );

    always #5 clk = ~clk;

    // The team's up-counter, driven only by the sequencer.
    always @(posedge clk) begin
        if (cnt_reset) count <= '0;
        else if (cnt_enable) count <= count + 8'd1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int cur_term = 0;

    typedef struct {
        int at;
        int cnt;
        int per;
    } done_exp_t;

    done_exp_t done_q[$];
    int        rst_q[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: samples 2ns after the falling edge, away from stimulus and clock.
    always @(negedge clk) begin
        done_exp_t e;
        int r;
        #2;
        if (!reset) begin
            tests++;
            if (cnt_enable && (cnt_reset || !busy || stop || pause || count == W'(cur_term))) begin
                fails++;
                $display("FAIL enable_rule: en=%0b rst=%0b busy=%0b stop=%0b pause=%0b count=%0d",
                         cnt_enable, cnt_reset, busy, stop, pause, count);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    e = done_q.pop_front();
                    check("done_cycle", cyc, e.at);
                    check("done_count", int'(count), e.cnt);
                    check("done_periods", int'(periods), e.per);
                end
            end
            if (cnt_reset) begin
                if (rst_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_cnt_reset: got one at cycle %0d, expected none", cyc);
                end else begin
                    r = rst_q.pop_front();
                    check("cnt_reset_cycle", cyc, r);
                end
            end
        end
    end

    // Cycle 0 is the cycle in which start is driven. A period is t+3 cycles; a pause
    // held for plen cycles from a RUN cycle stalls the count for plen+1 cycles
    // (the RUN cycle that sees pause plus every PAUSE cycle, including the exit one).
    task automatic run(input int t, input bit m, input int nper, input int pc,
                       input int plen, input bit stir);
        int base, stall, last;
        done_exp_t e;
        base = cyc;
        stall = (pc >= 0) ? plen + 1 : 0;
        cur_term = t;
        terminal = W'(t);
        mode = m;
        start = 1'b1;
        for (int j = 0; j < nper; j++) begin
            rst_q.push_back(base + 1 + (t + 3) * j + ((j > 0) ? stall : 0));
            e.at = base + (t + 3) * (j + 1) + stall;
            e.cnt = t;
            e.per = (j > 255) ? 255 : j;
            done_q.push_back(e);
        end
        last = base + (t + 3) * nper + stall;
        wait_cyc(base + 1);
        check("periods_cleared", int'(periods), 0);
        // Mid-run changes to start/terminal/mode must be ignored.
        start = stir;
        if (stir) begin
            terminal = W'($urandom);
            mode = 1'($urandom);
        end
        wait_cyc(base + 2);
        start = 1'b0;
        if (pc >= 0) begin
            wait_cyc(base + 2 + pc);
            pause = 1'b1;
            wait_cyc(base + 2 + pc + plen);
            pause = 1'b0;
        end
        if (m) begin
            wait_cyc(last);
            stop = 1'b1;
        end
        wait_cyc(last + 1);
        stop = 1'b0;
        check("busy_after_run", int'(busy), 0);
        check("periods_after_run", int'(periods), (nper > 255) ? 255 : nper);
        check("count_after_run", int'(count), t);
        check("missing_done", done_q.size(), 0);
        check("missing_cnt_reset", rst_q.size(), 0);
        done_q.delete();
        rst_q.delete();
    endtask

    task automatic run_abort(input int t, input int k);
        int base;
        base = cyc;
        cur_term = t;
        terminal = W'(t);
        mode = 1'($urandom);
        start = 1'b1;
        rst_q.push_back(base + 1);
        wait_cyc(base + 1);
        check("abort_periods_cleared", int'(periods), 0);
        start = 1'b0;
        wait_cyc(base + 2 + k);
        check("abort_count_before", int'(count), k);
        stop = 1'b1;
        wait_cyc(base + 3 + k);
        stop = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_count", int'(count), k);
        wait_cyc(base + 6 + k);
        check("abort_count_held", int'(count), k);
        check("abort_missing_cnt_reset", rst_q.size(), 0);
        rst_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, m, np, pc, pl;
        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        pause = 1'b0;
        mode = 1'b0;
        terminal = '0;
        #12;
        check("rst_cnt_enable", int'(cnt_enable), 0);
        check("rst_cnt_reset", int'(cnt_reset), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_periods", int'(periods), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run(10, 1'b0, 1, -1, 0, 1'b0);
        run(4, 1'b1, 4, -1, 0, 1'b0);
        run(10, 1'b0, 1, 3, 4, 1'b0);
        run_abort(10, 6);
        run(0, 1'b0, 1, -1, 0, 1'b0);
        run(255, 1'b0, 1, -1, 0, 1'b0);
        run(0, 1'b1, 258, -1, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            t = $urandom_range(0, 20);
            m = $urandom_range(0, 1);
            np = m ? $urandom_range(1, 4) : 1;
            pc = (t > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, t - 1) : -1;
            pl = $urandom_range(1, 4);
            run(t, 1'(m), np, pc, pl, 1'b1);
        end

        // Asynchronous reset in the second period of an auto-reload run.
        begin
            int base;
            done_exp_t e;
            base = cyc;
            cur_term = 3;
            terminal = 8'd3;
            mode = 1'b1;
            start = 1'b1;
            rst_q.push_back(base + 1);
            rst_q.push_back(base + 7);
            e.at = base + 6;
            e.cnt = 3;
            e.per = 0;
            done_q.push_back(e);
            wait_cyc(base + 1);
            start = 1'b0;
            wait_cyc(base + 9);
            start = 1'b1;
            terminal = 8'd0;
            wait_cyc(base + 10);
            check("pre_reset_busy", int'(busy), 1);
            check("pre_reset_periods", int'(periods), 1);
            #3;
            reset = 1'b1;
            #1;
            check("async_cnt_enable", int'(cnt_enable), 0);
            check("async_cnt_reset", int'(cnt_reset), 0);
            check("async_busy", int'(busy), 0);
            check("async_done", int'(done), 0);
            check("async_periods", int'(periods), 0);
            check("async_done_seen", done_q.size(), 0);
            check("async_resets_seen", rst_q.size(), 0);
            done_q.delete();
            rst_q.delete();
            start = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check("post_reset_busy", int'(busy), 0);
        end
        run(5, 1'b0, 1, -1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
